// File: rtl/falsepath_anchor.sv
`timescale 1ns/1ps
// falsepath_anchor
// Marks the point where an asynchronous reset enters a clock domain. Timing
// constraints cut paths at this cell, so every consumer of the incoming reset
// must take it from here rather than from the raw pin.
//
// Ports:
//   in_n   raw asynchronous active-low reset
//   out_n  anchored copy of in_n, for use inside the domain
module falsepath_anchor (
  input  logic in_n,
  output logic out_n
);

  assign out_n = in_n;

endmodule

// File: rtl/reset_seq.sv
`timescale 1ns/1ps
// reset_seq
// Root of one clock domain's reset tree. The asynchronous reset is
// synchronised and stretched, then N_CH active-low channel resets are
// released one at a time in ascending index order, GAP_CYCLES apart.
// Software can hold individual channels in reset, or replay the whole
// sequence from the stretch phase.
//
// Ports:
//   clk           domain clock
//   rst_n_in_fp   asynchronous active-low reset (asserts with no clock)
//   sw_rst_req    per-channel level hold; channel k is kept low while high
//   sw_rst_all    restart the release sequence; sampled every edge
//   rst_n_out     active-low channel resets, straight from flops
//   all_released  high once the last channel has been sequenced out
module reset_seq #(
  parameter int N_CH           = 4,
  parameter int SYNC_DEPTH     = 3,
  parameter int STRETCH_CYCLES = 8,
  parameter int GAP_CYCLES     = 2
) (
  input  logic            clk,
  input  logic            rst_n_in_fp,
  input  logic [N_CH-1:0] sw_rst_req,
  input  logic            sw_rst_all,
  output logic [N_CH-1:0] rst_n_out,
  output logic            all_released
);

  // The counter serves both the stretch (0..STRETCH_CYCLES) and the
  // inter-channel gap (GAP_CYCLES-1..0), so it is sized for the larger.
  localparam int CNT_MAX = (STRETCH_CYCLES + 1 > GAP_CYCLES) ? (STRETCH_CYCLES + 1) : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  logic                  rst_n;
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  sync_n;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_CH-1:0]       released_q, released_d;
  logic [N_CH-1:0]       rst_n_out_q, rst_n_out_d;
  logic                  all_released_q, all_released_d;

  falsepath_anchor u_rst_anchor (
    .in_n  (rst_n_in_fp),
    .out_n (rst_n)
  );

  // Synchroniser shifts in ones; its last stage gates the sequencer.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_n = sync_q[SYNC_DEPTH-1];

  // Sequencer next-state and output-register inputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    released_d     = released_q;
    all_released_d = all_released_q;

    if (sw_rst_all) begin
      // Replay overrides any sequencer progress on this edge, even
      // before the synchroniser has filled.
      state_d        = HOLD;
      cnt_d          = {CNT_W{1'b0}};
      idx_d          = {IDX_W{1'b0}};
      released_d     = {N_CH{1'b0}};
      all_released_d = 1'b0;
    end else if (sync_n) begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(STRETCH_CYCLES)) begin
            state_d = RELEASE;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(0)) begin
            for (int k = 0; k < N_CH; k++) begin
              if (idx_q == IDX_W'(k)) begin
                released_d[k] = 1'b1;
              end else begin
                released_d[k] = released_q[k];
              end
            end
            // Reloading with GAP-1 puts the next release exactly GAP edges later.
            cnt_d = CNT_W'(GAP_CYCLES - 1);
            if (idx_q == IDX_W'(N_CH - 1)) begin
              state_d        = RUN;
              all_released_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RUN: begin
          released_d = {N_CH{1'b1}};
        end
        default: begin
          // Unreachable encoding: restart the sequence from scratch.
          state_d        = HOLD;
          cnt_d          = {CNT_W{1'b0}};
          idx_d          = {IDX_W{1'b0}};
          released_d     = {N_CH{1'b0}};
          all_released_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Software holds mask the output only; the sequencer never sees them.
    rst_n_out_d = released_d & ~sw_rst_req;
  end

  // Synchroniser flops, cleared asynchronously by the anchored reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_DEPTH{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sequencer state and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HOLD;
      cnt_q          <= {CNT_W{1'b0}};
      idx_q          <= {IDX_W{1'b0}};
      released_q     <= {N_CH{1'b0}};
      rst_n_out_q    <= {N_CH{1'b0}};
      all_released_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      released_q     <= released_d;
      rst_n_out_q    <= rst_n_out_d;
      all_released_q <= all_released_d;
    end
  end

  assign rst_n_out    = rst_n_out_q;
  assign all_released = all_released_q;

endmodule

// File: tb/tb_reset_seq.sv
`timescale 1ns/1ps
// tb_reset_seq
// Drives three reset_seq instances (default, minimal single-channel, and
// back-to-back-release configurations) from a shared clock, async reset and
// replay request. Expected outputs come from a timing model: each instance
// has a reference edge t0, and channel k is released once the edge count
// reaches t0 + STRETCH + 2 + k*GAP, masked by that edge's software hold.
module tb_reset_seq;

  localparam int NCH [3] = '{4, 1, 3};
  localparam int DEP [3] = '{3, 2, 3};
  localparam int STR [3] = '{8, 0, 2};
  localparam int GAP [3] = '{2, 1, 1};

  logic       clk, clk_en;
  logic       rst_n_in, sw_all;
  logic [3:0] req_a, out_a;
  logic [0:0] req_b, out_b;
  logic [2:0] req_c, out_c;
  logic       all_a, all_b, all_c;

  int  total, bad;
  int  n, n0;
  bit  valid;
  int  t0 [3];

  reset_seq #(.N_CH(4), .SYNC_DEPTH(3), .STRETCH_CYCLES(8), .GAP_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n_in_fp(rst_n_in), .sw_rst_req(req_a), .sw_rst_all(sw_all),
    .rst_n_out(out_a), .all_released(all_a)
  );
  reset_seq #(.N_CH(1), .SYNC_DEPTH(2), .STRETCH_CYCLES(0), .GAP_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n_in_fp(rst_n_in), .sw_rst_req(req_b), .sw_rst_all(sw_all),
    .rst_n_out(out_b), .all_released(all_b)
  );
  reset_seq #(.N_CH(3), .SYNC_DEPTH(3), .STRETCH_CYCLES(2), .GAP_CYCLES(1)) u_dut_c (
    .clk(clk), .rst_n_in_fp(rst_n_in), .sw_rst_req(req_c), .sw_rst_all(sw_all),
    .rst_n_out(out_c), .all_released(all_c)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] get_out(int d);
    case (d)
      0:       return out_a;
      1:       return {3'b000, out_b};
      default: return {1'b0, out_c};
    endcase
  endfunction

  function automatic logic [3:0] get_req(int d);
    case (d)
      0:       return req_a;
      1:       return {3'b000, req_b};
      default: return {1'b0, req_c};
    endcase
  endfunction

  function automatic logic get_all(int d);
    case (d)
      0:       return all_a;
      1:       return all_b;
      default: return all_c;
    endcase
  endfunction

  // Model: channel k of instance d is out of reset after edge n.
  function automatic bit m_rel(int d, int k);
    return valid && (n >= t0[d] + STR[d] + 2 + k * GAP[d]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] o, r;
    bit e;
    for (int d = 0; d < 3; d++) begin
      o = get_out(d);
      r = get_req(d);
      for (int k = 0; k < NCH[d]; k++) begin
        e = m_rel(d, k) && !r[k];
        chk($sformatf("dut%0d_rst_n_out[%0d]@e%0d", d, k, n), {31'd0, o[k]}, {31'd0, e});
      end
      chk($sformatf("dut%0d_all_released@e%0d", d, n), {31'd0, get_all(d)},
          {31'd0, m_rel(d, NCH[d] - 1)});
    end
  endtask

  // One clock: update the model from inputs sampled at the edge, then check.
  task automatic step();
    @(posedge clk);
    n++;
    if (valid && sw_all) begin
      for (int d = 0; d < 3; d++) begin
        t0[d] = (n > n0 + DEP[d]) ? n : (n0 + DEP[d]);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int c);
    for (int i = 0; i < c; i++) step();
  endtask

  task automatic rst_assert();
    rst_n_in = 1'b0;
    valid    = 1'b0;
    #1;
    check_all();
  endtask

  task automatic rst_release();
    rst_n_in = 1'b1;
    n0       = n;
    valid    = 1'b1;
    for (int d = 0; d < 3; d++) t0[d] = n0 + DEP[d];
  endtask

  initial begin
    total = 0; bad = 0; n = 0; n0 = 0; valid = 1'b0;
    for (int d = 0; d < 3; d++) t0[d] = 0;
    clk_en = 1'b1; rst_n_in = 1'b1; sw_all = 1'b0;
    req_a = 4'b0000; req_b = 1'b0; req_c = 3'b000;

    #2;
    rst_assert();
    @(negedge clk);
    steps(3);

    // Power-on with channel 1 of the default instance held by software.
    req_a[1] = 1'b1;
    rst_release();
    steps(22);
    req_a[1] = 1'b0;
    steps(8);

    // Async reset between edges 16 and 17 of a sequence, clock stopped.
    rst_assert();
    steps(2);
    rst_release();
    steps(16);
    clk_en = 1'b0;
    #7;
    rst_assert();
    #4;
    rst_release();
    clk_en = 1'b1;
    steps(25);

    // Software hold of channel 2 while running.
    req_a[2] = 1'b1;
    steps(5);
    req_a[2] = 1'b0;
    steps(3);

    // Replay pulse in RUN, then again mid-release, then held high.
    sw_all = 1'b1; step(); sw_all = 1'b0;
    steps(12);
    sw_all = 1'b1; step(); sw_all = 1'b0;
    steps(20);
    sw_all = 1'b1; steps(4); sw_all = 1'b0;
    steps(20);

    // Randomised traffic.
    for (int it = 0; it < 600; it++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 15) == 0) req_a[k] = ~req_a[k];
      if ($urandom_range(0, 15) == 0) req_b[0] = ~req_b[0];
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 15) == 0) req_c[k] = ~req_c[k];
      sw_all = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_assert();
        steps($urandom_range(0, 2));
        rst_release();
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
